cs_job_scheduler: RTL and testbench



---
 rtl/cs_pkg.sv | 23 ++
 rtl/cs_rr_arbiter.sv | 35 +++
 rtl/cs_job_scheduler.sv | 135 +++++++++++++
 tb/tb_cs_job_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared definitions for the CS engine scheduler: field widths, job/result
// types, scheduler state encoding and the default watchdog limit.
package cs_pkg;

    localparam int WIDTH_DATA_1   = 384;
    localparam int WIDTH_DATA_2   = 128;
    localparam int WIDTH_RESULT_1 = 8;
    localparam int WIDTH_RESULT_2 = 8;
    localparam int JOB_W          = WIDTH_DATA_1 + WIDTH_DATA_2;
    localparam int RES_W          = WIDTH_RESULT_1 + WIDTH_RESULT_2;
    localparam int TIMEOUT_DEF    = 100;

    typedef logic [JOB_W-1:0] job_t;
    typedef logic [RES_W-1:0] result_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/cs_rr_arbiter.sv
// Combinational round-robin pick: searches last+1, last+2, ... modulo N and
// returns the first requester with valid set as one-hot, index and any flag.
module cs_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Rotating priority search starting just after the previous winner
    always_comb begin
        grant_o  = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= N; k++) begin
            cand     = (int'(last_i) + k) % N;
            cand_idx = IDX_W'(cand);
            if (!any_o && valid_i[cand_idx]) begin
                any_o             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/cs_job_scheduler.sv
// Shares one CS engine among N_REQ requesters: round-robin grant, one-cycle
// job strobe, watchdog-guarded wait for the result, then a held response.
module cs_job_scheduler
    import cs_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int WIDTH_DATA   = JOB_W,
    parameter int WIDTH_RESULT = RES_W,
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int ID_W         = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*WIDTH_DATA-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        eng_in_valid,
    output logic [WIDTH_DATA-1:0]       eng_data,
    input  logic                        eng_out_valid,
    input  logic [WIDTH_RESULT-1:0]     eng_result,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [ID_W-1:0]             resp_id,
    output logic [WIDTH_RESULT-1:0]     resp_result,
    output logic                        resp_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    sched_state_t            state_q, state_d;
    logic [ID_W-1:0]         last_q, last_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WIDTH_DATA-1:0]   job_q, job_d;
    logic [WIDTH_RESULT-1:0] result_q, result_d;

    logic [N_REQ-1:0]        grant;
    logic [ID_W-1:0]         g_idx;
    logic                    g_any;
    logic [WIDTH_DATA-1:0]   slot [N_REQ];

    // Split the flat request bus into one job word per requester
    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        assign slot[i] = req_data[i*WIDTH_DATA +: WIDTH_DATA];
    end

    cs_rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .valid_i (req_valid),
        .last_i  (last_q),
        .grant_o (grant),
        .idx_o   (g_idx),
        .any_o   (g_any)
    );

    // Next-state logic: grant, issue, watchdog wait (result beats timeout), respond
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        job_d    = job_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (g_any) begin
                    job_d   = slot[g_idx];
                    id_d    = g_idx;
                    last_d  = g_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_out_valid) begin
                    result_d = eng_result;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers; reset drops any in-flight job
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Job and result payload registers; only observed through gated outputs
    always_ff @(posedge clk) begin
        job_q    <= job_d;
        result_q <= result_d;
    end

    assign req_ready    = (state_q == S_IDLE) ? grant : '0;
    assign eng_in_valid = (state_q == S_ISSUE);
    assign eng_data     = eng_in_valid ? job_q : '0;
    assign resp_valid   = (state_q == S_RESP);
    assign resp_id      = resp_valid ? id_q : '0;
    assign resp_result  = (resp_valid && !err_q) ? result_q : '0;
    assign resp_err     = resp_valid & err_q;

endmodule

// File: tb/tb_cs_job_scheduler.sv
// Scoreboard bench for cs_job_scheduler: requester and engine models drive
// random jobs, expected responses are queued at issue and checked on output.
module tb_cs_job_scheduler;

    localparam int N  = 4;
    localparam int WD = 512;
    localparam int WR = 16;
    localparam int TO = 100;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*WD-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            eng_in_valid;
    logic [WD-1:0]   eng_data;
    logic            eng_out_valid;
    logic [WR-1:0]   eng_result;
    logic            resp_valid;
    logic            resp_ready;
    logic [IW-1:0]   resp_id;
    logic [WR-1:0]   resp_result;
    logic            resp_err;

    logic [WD-1:0]   job_a [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_rd
        assign req_data[gi*WD +: WD] = job_a[gi];
    end

    cs_job_scheduler #(
        .N_REQ(N), .WIDTH_DATA(WD), .WIDTH_RESULT(WR), .TIMEOUT(TO), .ID_W(IW)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .eng_in_valid(eng_in_valid), .eng_data(eng_data),
        .eng_out_valid(eng_out_valid), .eng_result(eng_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_err(resp_err)
    );

    typedef struct { int id; logic [WD-1:0] data; int cyc; } gnt_t;
    typedef struct { int id; logic [WR-1:0] res; logic err; int cyc; } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    int   glog[$];

    int n_chk = 0, n_fail = 0, cyc = 0;
    int jobs_left [N];
    bit gnt_seen [N];
    bit hold_mode = 1, rr_rand = 0, fixed_en = 0, eng_force = 0;
    logic [WR-1:0] fixed_res = '0, pend_res = '0;
    int eng_lat = 1, cd = 0, last_issue = -100;
    bit busy = 0, stall = 0, resp_first = 1, rst_prev = 0;
    int m_last = N - 1;
    logic [IW+WR:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [WD-1:0] act, input logic [WD-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [WD-1:0] rand_job();
        logic [WD-1:0] r;
        for (int k = 0; k < WD / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [WR-1:0] res_of(input logic [WD-1:0] d);
        return d[WR-1:0] ^ d[WD-1 -: WR] ^ 16'h0001;
    endfunction

    // Round-robin rule: first valid requester after the last winner
    function automatic int exp_grant(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic bit all_done();
        int s = 0;
        for (int i = 0; i < N; i++) s += jobs_left[i];
        return (s == 0) && (req_valid == '0) && !busy && gq.size() == 0 && rq.size() == 0;
    endfunction

    // Monitor: grant model, idle engine bus, response scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (rst_prev) begin
                chk("rst_eng_data", eng_data, '0);
                chki("rst_ctl", int'({req_ready, eng_in_valid, resp_valid, resp_id, resp_result, resp_err}), 0);
            end
            busy = 0; m_last = N - 1; stall = 0; resp_first = 1;
            gq.delete(); rq.delete();
        end else begin
            if (req_ready != '0) begin
                int ge, ga;
                ge = exp_grant(req_valid, m_last);
                ga = -1;
                for (int i = N - 1; i >= 0; i--) if (req_ready[i]) ga = i;
                chki("grant_while_busy", int'(busy), 0);
                chki("grant_onehot", int'(req_ready), (ge >= 0) ? (1 << ge) : 0);
                if (ga >= 0 && req_valid[ga]) begin
                    gnt_t g;
                    g.id = ga; g.data = job_a[ga]; g.cyc = cyc;
                    gq.push_back(g);
                    glog.push_back(ga);
                    m_last = ga; gnt_seen[ga] = 1; busy = 1;
                end
            end else if (!busy && req_valid != '0) begin
                chki("grant_missing", 0, 1);
            end
            if (!eng_in_valid) chk("eng_data_idle", eng_data, '0);
            if (resp_valid) begin
                if (rq.size() == 0) begin
                    chki("resp_unexpected", 1, 0);
                end else begin
                    if (resp_first) chki("resp_cycle", cyc, rq[0].cyc);
                    resp_first = 0;
                    if (stall) chki("resp_stable", int'({resp_id, resp_result, resp_err}), int'(held));
                    if (resp_ready) begin
                        chki("resp_id", int'(resp_id), rq[0].id);
                        chki("resp_result", int'(resp_result), int'(rq[0].res));
                        chki("resp_err", int'(resp_err), int'(rq[0].err));
                        void'(rq.pop_front());
                        busy = 0; stall = 0; resp_first = 1;
                    end else begin
                        stall = 1; held = {resp_id, resp_result, resp_err};
                    end
                end
            end else if (stall) begin
                chki("resp_dropped", 0, 1);
                stall = 0;
            end
        end
        rst_prev = rst;
    end

    // Requester model: present jobs, replace or drop after each grant
    initial begin
        for (int i = 0; i < N; i++) begin jobs_left[i] = 0; gnt_seen[i] = 0; end
        forever begin
            @(posedge clk); #1;
            if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                if (gnt_seen[i]) begin
                    gnt_seen[i] = 0; req_valid[i] = 1'b0;
                    if (jobs_left[i] > 0) jobs_left[i]--;
                end
                if (!req_valid[i] && jobs_left[i] > 0 && (hold_mode || $urandom_range(0, 2) == 0)) begin
                    req_valid[i] = 1'b1; job_a[i] = rand_job();
                end
            end
        end
    end

    // Engine model: check each issued job, queue the expected response
    initial begin
        forever begin
            @(posedge clk); #1;
            eng_out_valid = 1'b0; eng_result = WR'($urandom);
            if (rst) begin cd = 0; continue; end
            if (eng_force) begin eng_out_valid = 1'b1; eng_result = 16'hBEEF; eng_force = 0; end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin eng_out_valid = 1'b1; eng_result = pend_res; end
            end
            if (eng_in_valid) begin
                chki("issue_gap_ok", int'(cyc - last_issue >= 3), 1);
                last_issue = cyc;
                if (gq.size() == 0) begin
                    chki("issue_without_grant", 1, 0);
                end else begin
                    gnt_t g; rsp_t e; int lat;
                    g = gq.pop_front();
                    chk("eng_data", eng_data, g.data);
                    chki("issue_cycle", cyc, g.cyc + 1);
                    if (eng_lat > 0) lat = eng_lat;
                    else lat = ($urandom_range(0, 7) == 0) ? TO + 1 : int'($urandom_range(1, 15));
                    pend_res = fixed_en ? fixed_res : res_of(g.data);
                    e.id  = g.id;
                    e.err = (lat > TO);
                    e.res = e.err ? '0 : pend_res;
                    e.cyc = cyc + (e.err ? TO : lat) + 1;
                    rq.push_back(e);
                    cd = e.err ? 0 : lat;
                end
            end
        end
    end

    task automatic wait_done(input int maxc);
        int k = 0;
        while (!all_done() && k < maxc) begin @(negedge clk); k++; end
        chki("wait_done", int'(all_done()), 1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; cd = 0;
        for (int i = 0; i < N; i++) jobs_left[i] = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; resp_ready = 1'b1;
        eng_out_valid = 1'b0; eng_result = '0;
        for (int i = 0; i < N; i++) job_a[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single job with a fixed engine result after 5 cycles
        fixed_en = 1; fixed_res = 16'h3A5C; eng_lat = 5;
        jobs_left[0] = 1;
        wait_done(200);
        fixed_en = 0;

        // Round-robin with all requesters held valid and a fast engine
        do_reset();
        glog.delete(); eng_lat = 1;
        for (int i = 0; i < N; i++) jobs_left[i] = 2;
        wait_done(500);
        chki("rr_count", glog.size(), 8);
        for (int k = 0; k < 8 && k < glog.size(); k++) chki("rr_order", glog[k], k % N);

        // Watchdog abort, then a normal job
        eng_lat = TO + 1; jobs_left[1] = 1;
        wait_done(400);
        eng_lat = 3; jobs_left[1] = 1;
        wait_done(100);

        // Result on the final watchdog cycle is accepted
        eng_lat = TO; jobs_left[2] = 1;
        wait_done(400);

        // Backpressure: hold the response while requester 2 waits
        eng_lat = 2; resp_ready = 1'b0; jobs_left[0] = 1;
        for (int k = 0; k < 50 && !resp_valid; k++) @(negedge clk);
        chki("bp_resp_seen", int'(resp_valid), 1);
        jobs_left[2] = 1;
        repeat (10) begin
            @(negedge clk);
            chki("bp_req_ready", int'(req_ready), 0);
            chki("bp_resp_valid", int'(resp_valid), 1);
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chki("bp_grant_after_hs", int'(req_ready), 4);
        wait_done(100);

        // Reset while waiting on the engine; a late strobe must be ignored
        eng_lat = 50; jobs_left[0] = 1;
        for (int k = 0; k < 20 && !eng_in_valid; k++) @(negedge clk);
        chki("mid_issue_seen", int'(eng_in_valid), 1);
        repeat (5) @(negedge clk);
        do_reset();
        @(posedge clk); #1 eng_force = 1;
        repeat (5) begin
            @(negedge clk);
            chki("no_resp_after_rst", int'(resp_valid), 0);
        end
        glog.delete(); eng_lat = 2;
        jobs_left[0] = 1; jobs_left[3] = 1;
        wait_done(200);
        chki("post_rst_grants", glog.size(), 2);
        if (glog.size() > 0) chki("post_rst_first", glog[0], 0);

        // Random traffic: sporadic requests, random latency and backpressure
        hold_mode = 0; rr_rand = 1; eng_lat = 0;
        for (int i = 0; i < N; i++) jobs_left[i] = int'($urandom_range(2, 4));
        wait_done(20000);
        rr_rand = 0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
